neuron_mac_array: RTL
=====================

Name: neuron_mac_array

Overview:
Parametrised multi-lane fixed-point neuron for the MLP datapath. Consumes LANES input/weight pairs per beat over a valid/ready stream and accumulates NUM_INPUTS products onto a bias with saturation. Applies optional ReLU and presents one result per start on a valid/ready output. It succeeds the single-lane truncating MAC: it adds lanes, bias, saturation, a partial-beat mask, handshakes and completion control.

Parameters:
NUM_INPUTS, 784, dot-product length per neuron evaluation
LANES, 4, input/weight pairs consumed per beat
DATA_WIDTH, 8, signed width of each data and weight element
FRAC_BITS, 5, fractional bits of data, weight, bias and result
ACC_WIDTH, 16, signed accumulator and result width
RELU, 1, 1 = clamp negative results to 0; 0 = pass through

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin evaluation; sampled only in IDLE
bias  in  ACC_WIDTH  signed bias (FRAC_BITS fractional), captured on accepted start
in_valid  in  1  data_in/weight beat valid
in_ready  out  1  block accepts a beat
data_in  in  LANES*DATA_WIDTH  signed lanes, lane 0 in LSBs
weight  in  LANES*DATA_WIDTH  signed lanes, lane 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  ACC_WIDTH  signed neuron output
busy  out  1  high in every state except IDLE
overflow  out  1  sticky saturation flag for the current evaluation

Behaviour:
- Reset (async, immediate): state IDLE. in_ready, out_valid, busy, overflow, result, accumulator, beat counter and pipeline valid all 0.
- States: IDLE -> ACCUM on start. ACCUM -> DRAIN on acceptance of the last beat. DRAIN -> OUTPUT after 1 cycle. OUTPUT -> IDLE when out_valid && out_ready.
- On start in IDLE: accumulator <= bias, counter <= 0, overflow <= 0. start is ignored outside IDLE.
- in_ready = 1 only in ACCUM. A beat is accepted when in_valid && in_ready. BEATS = ceil(NUM_INPUTS/LANES); counter increments per accepted beat.
- Per lane: full 2*DATA_WIDTH signed product, arithmetic shift right by FRAC_BITS (truncate toward -inf).
- Partial last beat: lanes with index >= NUM_INPUTS - (BEATS-1)*LANES are forced to 0 regardless of input.
- Stage 1: lane products summed at full precision (2*DATA_WIDTH-FRAC_BITS+clog2(LANES) bits), registered with a valid bit on the accepting edge.
- Stage 2: the accumulator adds the stage-1 sum on the next edge. The add is done in ACC_WIDTH+guard bits and saturated to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets overflow, which holds until the next start. Once saturated, subsequent beats continue to accumulate from the clamped value.
- DRAIN covers the final stage-2 update. out_valid rises in the cycle after DRAIN, i.e. 2 cycles after the last accepting edge.
- result = RELU && acc<0 ? 0 : acc, registered on entry to OUTPUT.
- result and out_valid are held stable while out_ready is low. out_valid && out_ready returns to IDLE; start may be accepted the following cycle.
- in_valid during IDLE, DRAIN or OUTPUT is ignored; no beat is consumed.
- Reset mid-operation aborts the evaluation with no output. The next start behaves as from power-up.
- Gaps in in_valid stall the counter only; the result is independent of beat timing.

Test Plan:
All directed tests use NUM_INPUTS=8, LANES=4, DATA_WIDTH=8, FRAC_BITS=5, ACC_WIDTH=16 unless stated.
1. Basic: bias 0, all data 0x20 (1.0), all weights 0x10 (0.5), 2 back-to-back beats -> result 0x0080, overflow 0, out_valid 2 cycles after the 2nd acceptance.
2. Truncation/ReLU: data 0xFF, weights 0x01, bias 0 -> each product -1. RELU=0 gives result 0xFFF8; RELU=1 gives 0x0000.
3. Saturation: bias 0x7F00, data and weights 0x7F (product 504 each) -> result 0x7FFF, overflow 1. Next start with bias 0 and zero data -> overflow 0, result 0.
4. Partial beat (NUM_INPUTS=6): data/weights 0x20 on lanes 0-5, 0x7F on masked lanes 2-3 of beat 2 -> result 0x00C0.
5. Handshake: in_valid toggled every other cycle gives the same result as test 1. out_ready low 5 cycles keeps result/out_valid stable. start pulsed while busy is ignored.
6. Async reset asserted between edges mid-ACCUM -> busy, in_ready, out_valid, overflow drop immediately. A fresh test-1 run then yields 0x0080.

Source files
------------

// File: rtl/neuron_mac_array.sv
// Multi-lane fixed-point neuron: LANES products per beat, two-stage pipelined
// accumulate onto a bias with saturation, optional ReLU, valid/ready result.
module neuron_mac_array #(
    parameter int NUM_INPUTS = 784,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 5,
    parameter int ACC_WIDTH  = 16,
    parameter int RELU       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ACC_WIDTH-1:0]          bias,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in,
    input  logic [LANES*DATA_WIDTH-1:0]   weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          result,
    output logic                          busy,
    output logic                          overflow
);

    localparam int BEATS      = (NUM_INPUTS + LANES - 1) / LANES;
    localparam int LAST_LANES = NUM_INPUTS - (BEATS - 1) * LANES;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W     = 2 * DATA_WIDTH - FRAC_BITS;
    localparam int SUM_W      = PROD_W + $clog2(LANES);
    localparam int EXT_W      = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX =
        {{(EXT_W - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN =
        {{(EXT_W - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

    state_t                       state;
    state_t                       state_next;
    logic [CNT_W-1:0]             cnt;
    logic                         last_beat;
    logic                         accept;
    logic signed [PROD_W-1:0]     lane_prod [LANES];
    logic signed [SUM_W-1:0]      beat_sum;
    logic signed [SUM_W-1:0]      s1_sum;
    logic                         s1_valid;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [EXT_W-1:0]      wide_sum;
    logic                         sat_hit;
    logic [ACC_WIDTH-1:0]         relu_val;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    // Lanes past the end of the vector only exist on the final beat; zero them there.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]   d;
        logic signed [DATA_WIDTH-1:0]   w;
        logic signed [2*DATA_WIDTH-1:0] p;
        logic signed [PROD_W-1:0]       q;

        assign d = data_in[l*DATA_WIDTH +: DATA_WIDTH];
        assign w = weight[l*DATA_WIDTH +: DATA_WIDTH];
        assign p = d * w;
        assign q = PROD_W'(p >>> FRAC_BITS);

        if (l >= LAST_LANES) begin : g_masked
            assign lane_prod[l] = last_beat ? '0 : q;
        end else begin : g_plain
            assign lane_prod[l] = q;
        end
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + SUM_W'(lane_prod[i]);
        end
    end

    assign wide_sum = EXT_W'(acc) + EXT_W'(s1_sum);

    always_comb begin
        acc_next = acc;
        sat_hit  = 1'b0;
        if (s1_valid) begin
            if (wide_sum > ACC_MAX) begin
                acc_next = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
                sat_hit  = 1'b1;
            end else if (wide_sum < ACC_MIN) begin
                acc_next = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
                sat_hit  = 1'b1;
            end else begin
                acc_next = wide_sum[ACC_WIDTH-1:0];
            end
        end
    end

    assign relu_val = ((RELU != 0) && acc_next[ACC_WIDTH-1]) ? '0 : acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (accept && last_beat) state_next = DRAIN;
            DRAIN:   state_next = OUTPUT;
            OUTPUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result is taken from acc_next so the final stage-2 update lands in it during DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            result   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= beat_sum;
                cnt    <= cnt + CNT_W'(1);
            end
            if (state == IDLE && start) begin
                acc      <= bias;
                cnt      <= '0;
                overflow <= 1'b0;
            end else begin
                acc <= acc_next;
                if (sat_hit) overflow <= 1'b1;
            end
            if (state == DRAIN) begin
                result <= relu_val;
            end
        end
    end

endmodule
